// File: rtl/tpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tpu_pkg
// Description : Shared types and helpers for the systolic edge feeder.
// Revision    : 1.0 - initial release
// ============================================================================
package tpu_pkg;

  // Operand width of the MAC array
  localparam int DATA_SIZE = 16;

  // Edge feeder sequencing states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_STREAM = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_DONE   = 3'd4
  } feeder_state_e;

  // Drain length after the last beat: skew delay (n-1), edge-to-corner hops
  // (2*(n-1)) and the two-stage MAC pipeline (2).
  function automatic int flush_len(input int n);
    return 3 * (n - 1) + 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/skew_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : skew_delay_line
// Description : Single-lane register chain of configurable depth with a
//               synchronous zero-clear, used to skew one operand lane.
// Revision    : 1.0 - initial release
// ============================================================================
module skew_delay_line #(
  parameter int dataSize = 16,
  parameter int depth    = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear_i,
  input  logic [dataSize-1:0] data_i,
  output logic [dataSize-1:0] data_o
);

  logic [dataSize-1:0] stage_q [depth];

  // Shift the chain every cycle; clear wins over shift so a new tile starts clean
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < depth; k++) stage_q[k] <= '0;
    end else if (clear_i) begin
      for (int k = 0; k < depth; k++) stage_q[k] <= '0;
    end else begin
      stage_q[0] <= data_i;
      for (int k = 1; k < depth; k++) stage_q[k] <= stage_q[k-1];
    end
  end

  assign data_o = stage_q[depth-1];

endmodule
`default_nettype wire

// File: rtl/systolic_edge_feeder.sv
`default_nettype none
// ============================================================================
// Module      : systolic_edge_feeder
// Description : Accepts operand vectors over valid/ready, skews lane i by i
//               cycles onto the array edge and sequences the array-wide
//               clear/enable controls for one tile of kLen vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_edge_feeder
  import tpu_pkg::*;
#(
  parameter int dataSize = DATA_SIZE,
  parameter int arrayDim = 4,
  parameter int maxDepth = 256
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [$clog2(maxDepth+1)-1:0] kLen,
  input  logic                         inValid,
  output logic                         inReady,
  input  logic [arrayDim*dataSize-1:0] inData,
  output logic [arrayDim*dataSize-1:0] laneOut,
  output logic                         macClear,
  output logic                         macEnable,
  output logic                         busy,
  output logic                         done
);

  localparam int c_kw        = $clog2(maxDepth + 1);
  localparam int c_flush_len = flush_len(arrayDim);
  localparam int c_fw        = $clog2(c_flush_len);

  feeder_state_e state_q, state_d;
  logic [c_kw-1:0] klen_q, klen_d;
  logic [c_kw-1:0] beat_q, beat_d;
  logic [c_fw-1:0] flush_q, flush_d;

  logic [c_kw-1:0]              w_beat_inc;
  logic                         w_skew_clear;
  logic [arrayDim*dataSize-1:0] w_push;

  assign w_beat_inc = beat_q + c_kw'(1);
  assign busy       = (state_q != ST_IDLE);

  // Sequencer state and counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      klen_q  <= '0;
      beat_q  <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      klen_q  <= klen_d;
      beat_q  <= beat_d;
      flush_q <= flush_d;
    end
  end

  // Next-state, control outputs and skew input selection
  always_comb begin
    state_d      = state_q;
    klen_d       = klen_q;
    beat_d       = beat_q;
    flush_d      = flush_q;
    inReady      = 1'b0;
    macClear     = 1'b0;
    macEnable    = 1'b0;
    done         = 1'b0;
    w_skew_clear = 1'b0;
    w_push       = '0;
    case (state_q)
      ST_IDLE: begin
        // A zero-depth tile has nothing to compute, so it is dropped
        if (start && (kLen != '0)) begin
          klen_d  = kLen;
          beat_d  = '0;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        macClear     = 1'b1;
        w_skew_clear = 1'b1;
        state_d      = ST_STREAM;
      end
      ST_STREAM: begin
        inReady   = 1'b1;
        macEnable = 1'b1;
        // Bubbles push zeros (default) but do not advance the beat count
        if (inValid) begin
          w_push = inData;
          beat_d = w_beat_inc;
          if (w_beat_inc == klen_q) begin
            flush_d = '0;
            state_d = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        macEnable = 1'b1;
        if (flush_q == c_fw'(c_flush_len - 1)) begin
          state_d = ST_DONE;
        end else begin
          flush_d = flush_q + c_fw'(1);
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Lane i goes through i+1 registers so the vector leaves as a diagonal wavefront
  generate
    for (genvar i = 0; i < arrayDim; i++) begin : g_lane
      skew_delay_line #(
        .dataSize (dataSize),
        .depth    (i + 1)
      ) u_skew (
        .clk     (clk),
        .reset   (reset),
        .clear_i (w_skew_clear),
        .data_i  (w_push[i*dataSize +: dataSize]),
        .data_o  (laneOut[i*dataSize +: dataSize])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_systolic_edge_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_edge_feeder
// Description : Directed self-checking bench for systolic_edge_feeder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_edge_feeder;

  localparam int DW    = 16;
  localparam int AD    = 4;
  localparam int MD    = 256;
  localparam int KW    = $clog2(MD + 1);
  localparam int VW    = AD * DW;
  localparam int FLUSH = 11;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [KW-1:0] kLen;
  logic          inValid;
  logic          inReady;
  logic [VW-1:0] inData;
  logic [VW-1:0] laneOut;
  logic          macClear;
  logic          macEnable;
  logic          busy;
  logic          done;

  systolic_edge_feeder #(
    .dataSize (DW),
    .arrayDim (AD),
    .maxDepth (MD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .kLen      (kLen),
    .inValid   (inValid),
    .inReady   (inReady),
    .inData    (inData),
    .laneOut   (laneOut),
    .macClear  (macClear),
    .macEnable (macEnable),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_errors = 0;
  int            m;
  int            accepts;
  logic [VW-1:0] pushes[$];
  logic [VW-1:0] seen[int];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [VW-1:0] vec4(input int a3, input int a2, input int a1, input int a0);
    return {DW'(a3), DW'(a2), DW'(a1), DW'(a0)};
  endfunction

  // Lane i at m cycles after the first stream cycle carries lane i of the
  // vector pushed in stream cycle m-1-i.
  function automatic logic [VW-1:0] expect_lanes(input int mm);
    logic [VW-1:0] r;
    r = '0;
    for (int i = 0; i < AD; i++) begin
      int idx;
      idx = mm - 1 - i;
      if (idx >= 0 && idx < pushes.size()) r[i*DW +: DW] = pushes[idx][i*DW +: DW];
    end
    return r;
  endfunction

  task automatic begin_tile(input int k);
    start = 1'b1;
    kLen  = KW'(k);
    tick();
    start = 1'b0;
    check("clear_pulse", 64'(macClear), 64'd1);
    check("clear_ready", 64'(inReady), 64'd0);
    check("clear_busy", 64'(busy), 64'd1);
    tick();
    check("stream_ready", 64'(inReady), 64'd1);
    check("stream_noclear", 64'(macClear), 64'd0);
    check("stream_enable", 64'(macEnable), 64'd1);
    pushes.delete();
    seen.delete();
    m       = 0;
    accepts = 0;
  endtask

  task automatic push(input logic valid, input logic [VW-1:0] v);
    inValid = valid;
    inData  = v;
    if (valid && inReady) accepts++;
    pushes.push_back(valid ? v : '0);
    tick();
    m++;
    inValid = 1'b0;
    inData  = '0;
    seen[m] = laneOut;
    check("lanes_stream", laneOut, expect_lanes(m));
  endtask

  task automatic flush_and_done;
    for (int f = 0; f < FLUSH; f++) begin
      seen[m] = laneOut;
      check("flush_ready", 64'(inReady), 64'd0);
      check("flush_enable", 64'(macEnable), 64'd1);
      check("flush_nodone", 64'(done), 64'd0);
      check("lanes_flush", laneOut, expect_lanes(m));
      tick();
      m++;
    end
    check("done_pulse", 64'(done), 64'd1);
    check("done_enable", 64'(macEnable), 64'd0);
    check("done_lanes", laneOut, 64'd0);
    tick();
    check("done_single", 64'(done), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    kLen    = '0;
    inValid = 1'b0;
    inData  = '0;

    // 1. reset state
    #1;
    check("rst_lanes", laneOut, 64'd0);
    check("rst_ctrl", {60'd0, inReady, macClear, macEnable, done}, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("post_rst_ready", 64'(inReady), 64'd0);
    check("post_rst_busy", 64'(busy), 64'd0);

    // 2. single beat tile
    begin_tile(1);
    push(1'b1, vec4(4, 3, 2, 1));
    check("t2_flush_entry", 64'(inReady), 64'd0);
    check("t2_l0", laneOut, 64'h0000_0000_0000_0001);
    flush_and_done();
    check("t2_l1", seen[2], 64'h0000_0000_0002_0000);
    check("t2_l2", seen[3], 64'h0000_0003_0000_0000);
    check("t2_l3", seen[4], 64'h0004_0000_0000_0000);
    check("t2_after", seen[5], 64'd0);

    // 3. three back-to-back beats
    begin_tile(3);
    push(1'b1, vec4(1, 1, 1, 1));
    push(1'b1, vec4(2, 2, 2, 2));
    push(1'b1, vec4(3, 3, 3, 3));
    check("t3_accepts", 64'(accepts), 64'd3);
    flush_and_done();
    check("t3_l3_a", 64'(seen[4][63:48]), 64'd1);
    check("t3_l3_b", 64'(seen[5][63:48]), 64'd2);
    check("t3_l3_c", 64'(seen[6][63:48]), 64'd3);
    check("t3_diag", seen[3], 64'h0000_0001_0002_0003);

    // 4. bubble between two beats
    begin_tile(2);
    push(1'b1, vec4(5, 5, 5, 5));
    push(1'b0, vec4(9, 9, 9, 9));
    check("t4_still_stream", 64'(inReady), 64'd1);
    push(1'b1, vec4(7, 7, 7, 7));
    check("t4_flush_entry", 64'(inReady), 64'd0);
    flush_and_done();
    check("t4_l0_bubble", seen[2], 64'h0000_0000_0005_0000);
    check("t4_l0_second", seen[3], 64'h0000_0005_0000_0007);
    check("t4_l3_seq", {16'd0, seen[4][63:48], seen[5][63:48], seen[6][63:48]}, 64'h0000_0005_0000_0007);

    // 5. zero-depth start ignored; start while busy ignored
    start = 1'b1;
    kLen  = '0;
    tick();
    start = 1'b0;
    check("t5_k0_busy", 64'(busy), 64'd0);
    check("t5_k0_clear", 64'(macClear), 64'd0);
    for (int c = 0; c < 15; c++) begin
      check("t5_k0_nodone", {62'd0, done, inReady}, 64'd0);
      tick();
    end
    begin_tile(2);
    push(1'b1, vec4(1, 2, 3, 4));
    start = 1'b1;
    kLen  = KW'(5);
    push(1'b1, vec4(5, 6, 7, 8));
    start = 1'b0;
    check("t5_klen_kept", 64'(inReady), 64'd0);
    flush_and_done();

    // 6. reset mid-stream, then a clean tile
    begin_tile(4);
    push(1'b1, vec4(9, 9, 9, 9));
    push(1'b1, vec4(10, 10, 10, 10));
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_lanes", laneOut, 64'd0);
    check("t6_rst_ctrl", {59'd0, busy, inReady, macClear, macEnable, done}, 64'd0);
    tick();
    reset = 1'b0;
    tick();
    check("t6_idle", {62'd0, busy, done}, 64'd0);
    begin_tile(1);
    push(1'b1, vec4(8, 7, 6, 5));
    flush_and_done();
    check("t6_l0", seen[1], 64'h0000_0000_0000_0005);
    check("t6_l3", seen[4], 64'h0008_0000_0000_0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/systolic_edge_feeder.md
Name: systolic_edge_feeder

Overview:
- Upstream stage of the MAC systolic array. Accepts one arrayDim-wide operand vector per beat over a valid/ready handshake.
- Skews the vector so that lane i reaches the array edge i cycles after lane 0.
- Sequences the array-wide clear and enable controls for one tile of kLen vectors.
- Two instances are used per array, one on the left edge and one on the top edge. Both are driven by the same scheduler with identical start/kLen/inValid patterns.

Parameters:
- dataSize, 16, operand width (signed); matches the MAC data width.
- arrayDim, 4, lanes per vector = array rows/columns; must be >= 2.
- maxDepth, 256, maximum tile depth (vectors per tile).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a tile.
- kLen  in  $clog2(maxDepth+1)  tile depth; sampled on an accepted start.
- inValid  in  1  inData holds a valid vector.
- inReady  out  1  feeder accepts a vector this cycle.
- inData  in  arrayDim*dataSize  packed vector; lane i = bits [i*dataSize +: dataSize].
- laneOut  out  arrayDim*dataSize  skewed edge operands, same packing.
- macClear  out  1  broadcast accumulator clear.
- macEnable  out  1  broadcast accumulate enable.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the tile is fully drained.

Behaviour:
- Reset (asynchronous, active-high): state = IDLE; beat and flush counters = 0; all skew registers = 0. All outputs are 0: laneOut, inReady, macClear, macEnable, busy, done.
- States: IDLE, CLEAR, STREAM, FLUSH, DONE.
- IDLE:
  - Outputs low.
  - start with kLen != 0 → latch kLen, go to CLEAR.
  - start with kLen == 0 → ignored; stays IDLE; no done.
- CLEAR (1 cycle):
  - macClear = 1.
  - All skew registers are zeroed synchronously, so no stale data leaks from a previous tile.
  - → STREAM.
- STREAM:
  - inReady = 1, macEnable = 1.
  - A beat is accepted when inValid & inReady; the vector is pushed into the skew, and the beat count is incremented.
  - Cycle with inValid = 0: an all-zero vector is pushed (bubble); the count is not advanced. The skew shifts every cycle, never stalls.
  - Accepting beat number kLen → FLUSH.
- FLUSH:
  - inReady = 0, macEnable = 1; zero vectors are pushed.
  - Lasts exactly 3*(arrayDim-1)+2 cycles. This covers the skew delay, the edge-to-far-corner hop count, and the 2-stage MAC pipeline (multiply register, then accumulate with a registered enable).
  - → DONE.
- DONE (1 cycle): done = 1, macEnable = 0 → IDLE.
- Skew timing: a vector accepted at edge t appears on laneOut lane i during the cycle starting at edge t+1+i. lane0 passes through 1 register; lane i passes through i+1 registers.
- When not in STREAM, the input side of the skew is fed zeros.
- busy = (state != IDLE).
- start while busy → ignored.
- No arithmetic: data passes unmodified. Zero fill is two's-complement 0.
- Reset asserted mid-tile: immediate return to IDLE with all registers zero; no done pulse.

Decomposition:
- Package tpu_pkg:
  - feeder state enum typedef (IDLE/CLEAR/STREAM/FLUSH/DONE);
  - default DATA_SIZE = 16;
  - helper function for flush length, 3*(n-1)+2.
- Sub-module skew_delay_line (params dataSize, depth):
  - a per-lane register chain with a synchronous zero-clear input;
  - instantiated arrayDim times with depth = i+1.

Test Plan:
1. Reset assertion (arrayDim=4, dataSize=16) → all outputs 0; state IDLE; after release, inReady stays 0 until start.
2. start, kLen=1, one beat {lane3..lane0} = {4,3,2,1} accepted at edge t → expected response:
   - lane0=1 at t+1, lane1=2 at t+2, lane2=3 at t+3, lane3=4 at t+4; other lanes 0 in those cycles;
   - macClear high exactly 1 cycle before the first inReady;
   - FLUSH lasts 11 cycles, then a single done pulse.
3. kLen=3, back-to-back beats {1,1,1,1}, {2,2,2,2}, {3,3,3,3} → diagonal wavefront on laneOut; lane3 shows 1,2,3 at t+4..t+6; exactly 3 accepts.
4. kLen=2 with inValid low for 1 cycle between beats → a zero vector is inserted into every lane between the two values; beat count unaffected; FLUSH starts after the 2nd accept.
5. start with kLen=0 → no state change, done never pulses. start during STREAM → ignored; latched kLen unchanged.
6. Reset asserted in STREAM after 2 of kLen=4 beats → laneOut and controls 0 immediately. A subsequent start with kLen=1 streams correctly, with no residue from the aborted tile.
